// File: rtl/riscv_bus_pkg.sv
// rtl/riscv_bus_pkg.sv - shared bus defaults and command FSM state encoding
package riscv_bus_pkg;

    localparam int ADDR_W_DEFAULT          = 28;
    localparam int DATA_W_DEFAULT          = 32;
    localparam int MAX_OUTSTANDING_DEFAULT = 4;

    typedef enum logic {
        CMD_IDLE  = 1'b0,
        CMD_ISSUE = 1'b1
    } cmd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-in first-out buffer with occupancy count
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO can still accept a push when an entry leaves in the same cycle
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/avalon_mm_master.sv
// rtl/avalon_mm_master.sv - single-beat Avalon-MM master with read credits and response buffering
module avalon_mm_master
    import riscv_bus_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEFAULT,
    parameter int DATA_W          = DATA_W_DEFAULT,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                busy,
    output logic                err_unexpected,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_burstcount,
    output logic                avm_debugaccess,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CRD_W = CNT_W + 1;

    cmd_state_t       state;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CRD_W-1:0] credits_used;
    logic             credits_avail;
    logic             bus_free;
    logic             handshake;
    logic             read_accept;
    logic             rdv_ok;
    logic             rdv_stray;
    logic             rsp_pop;

    assign avm_burstcount  = 1'b1;
    assign avm_debugaccess = 1'b0;

    // A read holds its credit from handshake until the core pops its response
    always_comb begin
        credits_used  = CRD_W'(state == CMD_ISSUE && avm_read)
                      + CRD_W'(inflight)
                      + CRD_W'(fifo_count);
        credits_avail = (credits_used < CRD_W'(MAX_OUTSTANDING)) && !fifo_full;
    end

    // The bus frees up in the very cycle the pending command is accepted, so a new one can follow without a bubble
    assign bus_free    = (state == CMD_IDLE) || !avm_waitrequest;
    assign req_ready   = !reset && bus_free && (req_we || credits_avail);
    assign handshake   = req_valid && req_ready;
    assign read_accept = (state == CMD_ISSUE) && avm_read && !avm_waitrequest;
    assign rdv_ok      = avm_readdatavalid && (inflight != '0);
    assign rdv_stray   = avm_readdatavalid && (inflight == '0);
    assign rsp_valid   = !fifo_empty;
    assign rsp_pop     = rsp_valid && rsp_ready;
    assign busy        = (state == CMD_ISSUE) || (inflight != '0) || !fifo_empty;

    // Command FSM: load on handshake, hold every field while the slave stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= CMD_IDLE;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else if (handshake) begin
            state          <= CMD_ISSUE;
            avm_read       <= !req_we;
            avm_write      <= req_we;
            avm_address    <= req_addr & ~ADDR_W'(3);
            avm_writedata  <= req_wdata;
            avm_byteenable <= req_be;
        end else if (state == CMD_ISSUE && !avm_waitrequest) begin
            state     <= CMD_IDLE;
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
        end
    end

    // Reads accepted by the slave but whose data has not yet returned
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({read_accept, rdv_ok})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Sticky flag for read data that matches no outstanding read
    always_ff @(posedge clk) begin
        if (reset) begin
            err_unexpected <= 1'b0;
        end else if (rdv_stray) begin
            err_unexpected <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rdv_ok),
        .push_data (avm_readdata),
        .pop       (rsp_pop),
        .pop_data  (rsp_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: doc/avalon_mm_master.md
AVALON_MM_MASTER -- requirements
Module: avalon_mm_master

Interface
REQ-001 SHALL have parameters: ADDR_W, default 28, Avalon byte address width; DATA_W, default 32, data width; MAX_OUTSTANDING, default 4, read credit limit.
REQ-002 SHALL have one clock and a synchronous, active-high reset:
 clk  in  1  sole clock, rising edge
 reset  in  1  synchronous, active-high reset
REQ-003 SHALL have these core-side ports:
 req_valid  in  1  request present
 req_ready  out  1  request accepted when high together with req_valid
 req_we  in  1  1 = write, 0 = read
 req_addr  in  ADDR_W  byte address
 req_wdata  in  DATA_W  write data
 req_be  in  DATA_W/8  byte enables
 rsp_valid  out  1  read data present
 rsp_ready  in  1  core takes rsp_rdata
 rsp_rdata  out  DATA_W  read data
 busy  out  1  command pending, read in flight, or response buffered
 err_unexpected  out  1  sticky flag: readdatavalid seen with no read in flight
REQ-004 SHALL have these Avalon-MM master ports:
 avm_address  out  ADDR_W  byte address
 avm_read  out  1  read command
 avm_write  out  1  write command
 avm_writedata  out  DATA_W  write data
 avm_byteenable  out  DATA_W/8  byte enables
 avm_burstcount  out  1  constant 1
 avm_debugaccess  out  1  constant 0
 avm_waitrequest  in  1  slave stall
 avm_readdata  in  DATA_W  read data
 avm_readdatavalid  in  1  read data strobe

Function
REQ-005 SHALL contain a command FSM with two states. CMD_IDLE: avm_read = 0 and avm_write = 0. CMD_ISSUE: one command is asserted on the bus.
REQ-006 On a req_valid && req_ready handshake, the block SHALL register the address, data, byte enables and type, and enter CMD_ISSUE on the next cycle. The address is passed with bits [1:0] forced to 0.
REQ-007 In CMD_ISSUE, all avm_* command outputs SHALL stay stable while avm_waitrequest = 1. The command is accepted in the cycle where avm_waitrequest = 0.
REQ-008 req_ready SHALL equal (state == CMD_IDLE || !avm_waitrequest) && (req_we || credits_avail). This allows back-to-back issue with no bubble.
REQ-009 Writes SHALL be posted: no response is produced, and completion is the acceptance cycle.
REQ-010 credits_used SHALL equal (read pending in CMD_ISSUE) + reads in flight + response FIFO occupancy. credits_avail = credits_used < MAX_OUTSTANDING.
REQ-011 Each read accepted on the bus SHALL increment the in-flight count. Each avm_readdatavalid SHALL decrement it and push avm_readdata into the response FIFO. When both happen in the same cycle, the count is unchanged.
REQ-012 The response FIFO SHALL be MAX_OUTSTANDING deep and first-in first-out. rsp_valid = !empty and rsp_rdata = head entry. A pop occurs on rsp_valid && rsp_ready.
REQ-013 By construction of the credits, the FIFO SHALL never overflow. A push and a pop in the same cycle SHALL both take effect.
REQ-014 avm_readdatavalid with an in-flight count of 0 SHALL be dropped, with no push, and SHALL set err_unexpected. The flag is cleared only by reset.
REQ-015 Response latency from avm_readdatavalid to rsp_valid SHALL be 1 cycle.
REQ-016 busy SHALL be high whenever state == CMD_ISSUE, the in-flight count is nonzero, or the FIFO is non-empty.

Reset
REQ-017 Reset SHALL act at the clock edge and set: state = CMD_IDLE; avm_read = 0; avm_write = 0; avm_address, avm_writedata and avm_byteenable = 0; in-flight count = 0; FIFO empty; rsp_valid = 0; err_unexpected = 0; busy = 0.
REQ-018 Reset asserted mid-transaction SHALL abandon the pending command and all in-flight reads. Any avm_readdatavalid arriving after reset deasserts SHALL be handled per REQ-014.
REQ-019 While reset = 1, req_ready SHALL be 0.

Structure
REQ-020 The default width parameters and the FSM state enum SHALL live in the shared package riscv_bus_pkg.
REQ-021 The response FIFO SHALL be a separate sub-module, sync_fifo (parameterised width and depth, with full, empty and count outputs).

Verification
REQ-022 Write to 0x0000010 with data 0xDEADBEEF and be 0xF, waitrequest high for 3 cycles: avm_write is held for 4 cycles with stable fields, req_ready = 0 for cycles 1–3, and no rsp_valid.
REQ-023 Four back-to-back reads with waitrequest = 0 and rsp_ready = 0: all four are issued on consecutive cycles, a fifth read gets req_ready = 0, and readdatavalid data 1, 2, 3, 4 emerges in order once rsp_ready = 1.
REQ-024 readdatavalid and a read acceptance in the same cycle with the count at 2: the count stays at 2 and the FIFO gains 1 entry.
REQ-025 readdatavalid while idle and the count is 0: err_unexpected = 1, rsp_valid stays 0, and the flag persists until reset.
REQ-026 Reset asserted with 2 reads in flight and 1 buffered response: the next cycle has avm_read = 0, rsp_valid = 0 and busy = 0.
REQ-027 Read of address 0x0000013: avm_address = 0x0000010.
